// File: rtl/fwd_hazard_ctrl.sv
// fwd_hazard_ctrl: EX-stage operand-forwarding select scheduler and load-use
// stall generator. It keeps a shadow copy of the EX/MEM destination scoreboard
// and advances in lockstep with the ID/EX pipeline register.
module fwd_hazard_ctrl #(
   parameter int ADDR_W = 5,
   parameter int CNT_W  = 16
) (
   input  logic              clk_i,
   input  logic              rst_i,          // synchronous, active-low
   input  logic              id_valid_i,
   input  logic [ADDR_W-1:0] id_rs_i,
   input  logic [ADDR_W-1:0] id_rt_i,
   input  logic              id_uses_rs_i,
   input  logic              id_uses_rt_i,
   input  logic [ADDR_W-1:0] id_rd_i,
   input  logic              id_regwrite_i,
   input  logic              id_memread_i,
   input  logic              flush_i,
   input  logic              mem_stall_i,
   output logic [1:0]        fwdA_o,
   output logic [1:0]        fwdB_o,
   output logic              stall_o,
   output logic [CNT_W-1:0]  stall_cnt_o
);

   // Forwarding-mux select encoding; 2'b11 is never produced.
   typedef enum logic [1:0] {
      SEL_RF  = 2'b00,
      SEL_WB  = 2'b01,
      SEL_MEM = 2'b10
   } fwd_sel_e;

   // Shadow scoreboard of the instructions currently in EX and MEM.
   logic              ex_valid, ex_regwrite, ex_memread;
   logic [ADDR_W-1:0] ex_rd;
   logic              mem_valid, mem_regwrite;
   logic [ADDR_W-1:0] mem_rd;
   fwd_sel_e          fwd_a_q, fwd_b_q;
   logic [CNT_W-1:0]  cnt;

   logic              lu;
   logic              ex_prod, mem_prod;
   fwd_sel_e          fwd_a_d, fwd_b_d;

   // Load-use detection and stall; flush wins because the dependant is squashed anyway.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path can infer a latch.
      lu      = 1'b0;
      ex_prod = ex_valid & ex_regwrite & (ex_rd != '0);
      if (ex_prod && ex_memread && id_valid_i)
         lu = (id_uses_rs_i && (id_rs_i == ex_rd)) ||
              (id_uses_rt_i && (id_rt_i == ex_rd));
      stall_o = lu & ~flush_i;
   end

   // Next forwarding selects for the ID instruction; the youngest producer (EX) wins.
   always_comb begin
      fwd_a_d  = SEL_RF;
      fwd_b_d  = SEL_RF;
      mem_prod = mem_valid & mem_regwrite & (mem_rd != '0);
      if (id_uses_rs_i) begin
         if (ex_prod && (ex_rd == id_rs_i))
            fwd_a_d = SEL_MEM;
         else if (mem_prod && (mem_rd == id_rs_i))
            fwd_a_d = SEL_WB;
      end
      if (id_uses_rt_i) begin
         if (ex_prod && (ex_rd == id_rt_i))
            fwd_b_d = SEL_MEM;
         else if (mem_prod && (mem_rd == id_rt_i))
            fwd_b_d = SEL_WB;
      end
   end

   // Pipeline advance: reset overrides freeze; freeze holds every register, flush included.
   always_ff @(posedge clk_i) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      if (!rst_i) begin
         // NOTE: payload fields are reset too; it is a handful of flops, not a memory array.
         ex_valid     <= 1'b0;
         ex_regwrite  <= 1'b0;
         ex_memread   <= 1'b0;
         ex_rd        <= '0;
         mem_valid    <= 1'b0;
         mem_regwrite <= 1'b0;
         mem_rd       <= '0;
         fwd_a_q      <= SEL_RF;
         fwd_b_q      <= SEL_RF;
         cnt          <= '0;
      end else if (!mem_stall_i) begin
         mem_valid    <= ex_valid;
         mem_regwrite <= ex_regwrite;
         mem_rd       <= ex_rd;
         if (stall_o || flush_i) begin
            // Bubble: only the valid bit matters, payload is don't-care.
            ex_valid <= 1'b0;
            fwd_a_q  <= SEL_RF;
            fwd_b_q  <= SEL_RF;
         end else begin
            ex_valid    <= id_valid_i;
            ex_regwrite <= id_regwrite_i;
            ex_memread  <= id_memread_i;
            ex_rd       <= id_rd_i;
            fwd_a_q     <= fwd_a_d;
            fwd_b_q     <= fwd_b_d;
         end
         if (stall_o && (cnt != {CNT_W{1'b1}}))
            cnt <= cnt + CNT_W'(1);
      end
   end

   assign fwdA_o      = fwd_a_q;
   assign fwdB_o      = fwd_b_q;
   assign stall_cnt_o = cnt;

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Directed bench for fwd_hazard_ctrl: forwarding priority, load-use stall,
// flush, freeze, counter saturation (CNT_W=2) and reset during a stall.
module tb_fwd_hazard_ctrl;

   localparam int ADDR_W = 5;
   localparam int CNT_W  = 2;

   logic              clk_i = 1'b0;
   logic              rst_i;
   logic              id_valid_i, id_uses_rs_i, id_uses_rt_i;
   logic              id_regwrite_i, id_memread_i, flush_i, mem_stall_i;
   logic [ADDR_W-1:0] id_rs_i, id_rt_i, id_rd_i;
   logic [1:0]        fwdA_o, fwdB_o;
   logic              stall_o;
   logic [CNT_W-1:0]  stall_cnt_o;

   int n_checks = 0;
   int n_pass   = 0;

   fwd_hazard_ctrl #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .id_valid_i(id_valid_i), .id_rs_i(id_rs_i), .id_rt_i(id_rt_i),
      .id_uses_rs_i(id_uses_rs_i), .id_uses_rt_i(id_uses_rt_i),
      .id_rd_i(id_rd_i), .id_regwrite_i(id_regwrite_i), .id_memread_i(id_memread_i),
      .flush_i(flush_i), .mem_stall_i(mem_stall_i),
      .fwdA_o(fwdA_o), .fwdB_o(fwdB_o), .stall_o(stall_o), .stall_cnt_o(stall_cnt_o)
   );

   // 10 ns clock
   always #5 clk_i = ~clk_i;

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   // Advance one edge, then settle away from it.
   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   // Present an instruction in ID: valid, rs, rt, uses_rs, uses_rt, rd, regwrite, memread.
   task automatic set_id(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                         input logic urs, input logic urt, input logic [4:0] rd,
                         input logic rw, input logic mr);
      id_valid_i    = v;
      id_rs_i       = rs;
      id_rt_i       = rt;
      id_uses_rs_i  = urs;
      id_uses_rt_i  = urt;
      id_rd_i       = rd;
      id_regwrite_i = rw;
      id_memread_i  = mr;
      #1;
   endtask

   task automatic nop();
      set_id(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
   endtask

   task automatic idle(input int n);
      nop();
      for (int i = 0; i < n; i++) tick();
   endtask

   initial begin
      rst_i = 1'b0;
      flush_i = 1'b0;
      mem_stall_i = 1'b0;
      nop();

      // 1: reset then idle
      tick(); tick();
      check("rst_fwdA", fwdA_o, 2'b00);
      check("rst_fwdB", fwdB_o, 2'b00);
      check("rst_stall", stall_o, 1'b0);
      check("rst_cnt", stall_cnt_o, 2'd0);
      rst_i = 1'b1;
      idle(3);
      check("idle_fwdA", fwdA_o, 2'b00);
      check("idle_fwdB", fwdB_o, 2'b00);
      check("idle_stall", stall_o, 1'b0);
      check("idle_cnt", stall_cnt_o, 2'd0);

      // 2: ADD $3 ; SUB rs=$3 back-to-back -> EX forward
      set_id(1, 5'd1, 5'd2, 1, 1, 5'd3, 1, 0); tick();
      set_id(1, 5'd3, 5'd4, 1, 1, 5'd6, 1, 0);
      check("b2b_nostall", stall_o, 1'b0);
      tick();
      check("b2b_fwdA", fwdA_o, 2'b10);
      check("b2b_fwdB", fwdB_o, 2'b00);
      idle(2);
      // ADD $3 ; NOP ; SUB rs=$3 -> MEM/WB forward
      set_id(1, 5'd1, 5'd2, 1, 1, 5'd3, 1, 0); tick();
      nop(); tick();
      set_id(1, 5'd3, 5'd4, 1, 1, 5'd6, 1, 0); tick();
      check("gap_fwdA", fwdA_o, 2'b01);
      check("gap_fwdB", fwdB_o, 2'b00);
      idle(2);

      // 3: ADD $3 ; ADD $3 ; OR rt=$3 -> EX beats MEM
      set_id(1, 5'd1, 5'd2, 1, 1, 5'd3, 1, 0); tick();
      set_id(1, 5'd1, 5'd2, 1, 1, 5'd3, 1, 0); tick();
      set_id(1, 5'd1, 5'd3, 1, 1, 5'd8, 1, 0); tick();
      check("prio_fwdB", fwdB_o, 2'b10);
      check("prio_fwdA", fwdA_o, 2'b00);
      idle(2);
      // same with rd=$0 -> never forwarded
      set_id(1, 5'd1, 5'd2, 1, 1, 5'd0, 1, 0); tick();
      set_id(1, 5'd1, 5'd2, 1, 1, 5'd0, 1, 0); tick();
      set_id(1, 5'd1, 5'd0, 1, 1, 5'd8, 1, 0); tick();
      check("r0_fwdB", fwdB_o, 2'b00);
      idle(2);

      // 4: LW $5 ; AND rs=$5 -> one bubble, then WB forward
      set_id(1, 5'd1, 5'd0, 1, 0, 5'd5, 1, 1); tick();
      set_id(1, 5'd5, 5'd6, 1, 1, 5'd7, 1, 0);
      check("lu_stall", stall_o, 1'b1);
      tick();
      check("lu_stall_drop", stall_o, 1'b0);
      check("lu_bubble_fwdA", fwdA_o, 2'b00);
      check("lu_cnt", stall_cnt_o, 2'd1);
      tick();
      check("lu_fwdA", fwdA_o, 2'b01);
      check("lu_fwdB", fwdB_o, 2'b00);
      idle(2);

      // 5a: LW $5 ; dependant with flush -> no stall, dependant squashed
      set_id(1, 5'd1, 5'd0, 1, 0, 5'd5, 1, 1); tick();
      set_id(1, 5'd5, 5'd6, 1, 1, 5'd7, 1, 0);
      flush_i = 1'b1; #1;
      check("fl_stall", stall_o, 1'b0);
      tick();
      flush_i = 1'b0;
      set_id(1, 5'd7, 5'd0, 1, 0, 5'd9, 1, 0); tick();
      check("fl_squash_fwdA", fwdA_o, 2'b00);
      check("fl_cnt", stall_cnt_o, 2'd1);
      idle(2);

      // 5b: ADD $1 ; LW $5 rs=$1 ; AND rs=$5 frozen for 4 cycles
      set_id(1, 5'd2, 5'd0, 1, 0, 5'd1, 1, 0); tick();
      set_id(1, 5'd1, 5'd0, 1, 0, 5'd5, 1, 1); tick();
      check("fz_pre_fwdA", fwdA_o, 2'b10);
      set_id(1, 5'd5, 5'd6, 1, 1, 5'd7, 1, 0);
      mem_stall_i = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         check("fz_fwdA", fwdA_o, 2'b10);
         check("fz_stall", stall_o, 1'b1);
         check("fz_cnt", stall_cnt_o, 2'd1);
      end
      mem_stall_i = 1'b0;
      tick();
      check("fz_bubble_fwdA", fwdA_o, 2'b00);
      check("fz_stall_drop", stall_o, 1'b0);
      check("fz_cnt_after", stall_cnt_o, 2'd2);
      tick();
      check("fz_resume_fwdA", fwdA_o, 2'b01);
      idle(2);

      // 6: three more load-use events -> 5 total, counter saturates at 3
      for (int i = 0; i < 3; i++) begin
         set_id(1, 5'd1, 5'd0, 1, 0, 5'd5, 1, 1); tick();
         set_id(1, 5'd6, 5'd5, 1, 1, 5'd7, 1, 0);
         check("sat_stall", stall_o, 1'b1);
         tick();
         check("sat_cnt", stall_cnt_o, 2'd3);
         idle(2);
      end

      // reset while a load-use stall is active
      set_id(1, 5'd1, 5'd0, 1, 0, 5'd5, 1, 1); tick();
      set_id(1, 5'd5, 5'd6, 1, 1, 5'd7, 1, 0);
      check("rs_stall_pre", stall_o, 1'b1);
      rst_i = 1'b0;
      tick();
      check("rs_stall_drop", stall_o, 1'b0);
      check("rs_cnt", stall_cnt_o, 2'd0);
      check("rs_fwdA", fwdA_o, 2'b00);
      rst_i = 1'b1;
      idle(1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
